// File: rtl/rca_pkg.sv
// Shared definitions for the sequential ripple-carry controller:
// FSM state encoding, slice width, default operand width and counter sizing.
package rca_pkg;

   localparam int SLICE_W       = 4;
   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slice counter width; a single-slice build still needs a 1-bit counter.
   function automatic int cnt_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/rca_seq_ctrl_rca.sv
// 4-bit ripple-carry adder slice, shared by the sequential controller.
module rca
   import rca_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               carry_i,
   output logic [SLICE_W-1:0] sum_o,
   output logic               carry_o
);

   logic [SLICE_W:0] c_chain;

   assign c_chain[0] = carry_i;

   for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
      assign sum_o[gi]      = a_i[gi] ^ b_i[gi] ^ c_chain[gi];
      assign c_chain[gi+1]  = (a_i[gi] & b_i[gi]) | (c_chain[gi] & (a_i[gi] ^ b_i[gi]));
   end

   assign carry_o = c_chain[SLICE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequential adder: one 4-bit slice per cycle through a single shared rca.
// Optional signed-overflow output ovf_o is built when RCA_SEQ_OVF_EN is defined.
module rca_seq_ctrl
   import rca_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
`ifdef RCA_SEQ_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int NIB   = WIDTH / SLICE_W;
   localparam int CNT_W = cnt_width(NIB);
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NIB - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               carry_reg, carry_next;
   logic [WIDTH-1:0]   a_reg, a_next;
   logic [WIDTH-1:0]   b_reg, b_next;
   logic [WIDTH-1:0]   sum_reg, sum_next;
   logic               cout_reg, cout_next;

   logic [SLICE_W-1:0] a_slice [NIB];
   logic [SLICE_W-1:0] b_slice [NIB];
   logic [SLICE_W-1:0] a_cur, b_cur, add_sum;
   logic               add_cout;
   logic               run_en;

   for (genvar gi = 0; gi < NIB; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_slice[gi] = b_reg[gi*SLICE_W +: SLICE_W];
      // Only the slice under the counter is overwritten; the rest hold.
      assign sum_next[gi*SLICE_W +: SLICE_W] =
         (run_en && (cnt_reg == CNT_W'(gi))) ? add_sum : sum_reg[gi*SLICE_W +: SLICE_W];
   end

   assign run_en = (state_reg == RUN);
   assign a_cur  = a_slice[cnt_reg];
   assign b_cur  = b_slice[cnt_reg];

   rca u_rca (
      .a_i     (a_cur),
      .b_i     (b_cur),
      .carry_i (carry_reg),
      .sum_o   (add_sum),
      .carry_o (add_cout)
   );

`ifdef RCA_SEQ_OVF_EN
   logic ovf_reg, ovf_next;
   logic msb_cin;

   // Carry into the top bit of the slice, recovered from its sum bit.
   assign msb_cin = a_cur[SLICE_W-1] ^ b_cur[SLICE_W-1] ^ add_sum[SLICE_W-1];
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      carry_next = carry_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      cout_next  = cout_reg;
`ifdef RCA_SEQ_OVF_EN
      ovf_next   = ovf_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (req_valid_i) begin
               a_next     = a_i;
               b_next     = b_i;
               carry_next = carry_i;
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            carry_next = add_cout;
            if (cnt_reg == LAST_SLICE) begin
               cout_next  = add_cout;
`ifdef RCA_SEQ_OVF_EN
               ovf_next   = msb_cin ^ add_cout;
`endif
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            if (res_ready_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
         ovf_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         carry_reg <= carry_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
`ifdef RCA_SEQ_OVF_EN
         ovf_reg   <= ovf_next;
`endif
      end
   end

   assign req_ready_o = (state_reg == IDLE);
   assign res_valid_o = (state_reg == DONE);
   assign sum_o       = sum_reg;
   assign carry_o     = cout_reg;
`ifdef RCA_SEQ_OVF_EN
   assign ovf_o       = ovf_reg;
`endif

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: transaction-level reference model with per-cycle
// comparison, directed corner cases and randomized operations.
module tb_rca_seq_ctrl;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] sum;
   logic         carry_out;
`ifdef RCA_SEQ_OVF_EN
   logic         ovf;
`endif

   always #5 clk = ~clk;

   rca_seq_ctrl #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .a_i         (a),
      .b_i         (b),
      .carry_i     (carry_in),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .sum_o       (sum),
      .carry_o     (carry_out)
`ifdef RCA_SEQ_OVF_EN
      ,
      .ovf_o       (ovf)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an operation is busy from acceptance until its result
   // is taken; the result appears NIB cycles after acceptance.
   bit         m_live  = 0;
   bit         m_busy  = 0;
   bit         m_valid = 0;
   bit         m_clean = 1;
   int         m_cnt   = 0;
   logic [W:0] m_res   = '0;
   bit         m_ovf   = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_live  = 1;
         m_busy  = 0;
         m_valid = 0;
         m_clean = 1;
      end else if (m_live) begin
         if (!m_busy) begin
            if (req_valid) begin
               m_busy  = 1;
               m_cnt   = 0;
               m_res   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
               m_ovf   = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
               m_clean = 0;
            end
         end else if (!m_valid) begin
            m_cnt++;
            if (m_cnt == NIB) m_valid = 1;
         end else if (res_ready) begin
            m_busy  = 0;
            m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("req_ready", 32'(req_ready), 32'(!m_busy));
         check("res_valid", 32'(res_valid), 32'(m_valid));
         if (m_valid) begin
            check("result", 32'({carry_out, sum}), 32'(m_res));
`ifdef RCA_SEQ_OVF_EN
            check("ovf", 32'(ovf), 32'(m_ovf));
`endif
         end else if (m_clean) begin
            check("reset_result", 32'({carry_out, sum}), 32'd0);
`ifdef RCA_SEQ_OVF_EN
            check("reset_ovf", 32'(ovf), 32'd0);
`endif
         end
      end
   end

   task automatic wait_valid(output int edges);
      edges = 0;
      while (!res_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         req_valid = 1'($urandom);
         a         = W'($urandom);
         b         = W'($urandom);
         carry_in  = 1'($urandom);
      end
      if (!res_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: res_valid never rose, waited %0d cycles", edges);
      end
   endtask

   // One full operation: request, result with 'hold' cycles of backpressure,
   // then result handshake. Optional literal expectations pin the model.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input int hold, input bit lit, input logic [W:0] exp_lit,
                         input bit exp_ovf);
      int edges;
      @(negedge clk);
      req_valid = 1'b1;
      a         = ta;
      b         = tb_v;
      carry_in  = tc;
      res_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      a         = W'($urandom);
      b         = W'($urandom);
      wait_valid(edges);
      if (lit) begin
         check("latency", 32'(edges), 32'(NIB));
         check("lit_result", 32'({carry_out, sum}), 32'(exp_lit));
`ifdef RCA_SEQ_OVF_EN
         check("lit_ovf", 32'(ovf), 32'(exp_ovf));
`else
         if (exp_ovf) begin end
`endif
      end
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'($urandom);
         a         = W'($urandom);
         b         = W'($urandom);
         if (lit) begin
            check("hold_result", 32'({carry_out, sum}), 32'(exp_lit));
            check("hold_ready", 32'(req_ready), 32'd0);
         end
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      $display("txn a=%h b=%h cin=%0d -> carry=%0d sum=%h lat=%0d hold=%0d",
               ta, tb_v, tc, carry_out, sum, edges, hold);
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      check("idle_after_handshake", 32'(req_ready), 32'd1);
   endtask

   initial begin
      int edges;
      rst       = 1'b1;
      req_valid = 1'b0;
      res_ready = 1'b0;
      a         = '0;
      b         = '0;
      carry_in  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(res_valid), 32'd0);
      rst = 1'b0;

      run_op(16'h1234, 16'h0FFF, 1'b0, 3, 1, 17'h0_2233, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1, 17'h1_0000, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b1, 1, 1, 17'h1_0001, 1'b1);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1, 17'h0_8000, 1'b1);

      // Abort in the second RUN cycle.
      @(negedge clk);
      req_valid = 1'b1;
      a         = 16'hAAAA;
      b         = 16'h5555;
      carry_in  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_valid", 32'(res_valid), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      $display("txn a=aaaa b=5555 cin=0 -> aborted by reset");
      run_op(16'h0009, 16'h0009, 1'b1, 0, 1, 17'h0_0013, 1'b0);

      // Back-to-back with res_ready tied high and req_valid held.
      @(negedge clk);
      res_ready = 1'b1;
      req_valid = 1'b1;
      a         = 16'h1111;
      b         = 16'h2222;
      carry_in  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a         = 16'hF000;
      b         = 16'h1000;
      carry_in  = 1'b1;
      edges = 0;
      while (!res_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("b2b_first", 32'({carry_out, sum}), 32'h0_3333);
      $display("txn a=1111 b=2222 cin=0 -> carry=%0d sum=%h lat=%0d", carry_out, sum, edges);
      @(posedge clk);
      @(negedge clk);
      check("b2b_ready_gap", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_second_accept", 32'(req_ready), 32'd0);
      edges = 0;
      while (!res_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("b2b_second", 32'({carry_out, sum}), 32'h1_0001);
      $display("txn a=f000 b=1000 cin=1 -> carry=%0d sum=%h lat=%0d", carry_out, sum, edges);
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;

      for (int i = 0; i < 40; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3),
                0, '0, 1'b0);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant: NIB = WIDTH/4, number of 4-bit slices processed per operation.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  1  operation request valid.
REQ-006 req_ready_o  output  1  controller can accept a request.
REQ-007 a_i  input  WIDTH  operand A, captured on request handshake.
REQ-008 b_i  input  WIDTH  operand B, captured on request handshake.
REQ-009 carry_i  input  1  carry-in to slice 0, captured on request handshake.
REQ-010 res_valid_o  output  1  result valid.
REQ-011 res_ready_i  input  1  consumer accepts the result.
REQ-012 sum_o  output  WIDTH  result sum.
REQ-013 carry_o  output  1  carry-out of the most significant slice.

Function
REQ-014 The block SHALL compute {carry_o, sum_o} = a_i + b_i + carry_i modulo 2^(WIDTH+1) by driving one shared 4-bit ripple-carry adder, one slice per cycle.
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE: req_ready_o=1; on req_valid_i&&req_ready_o, the block SHALL latch operands and carry_i, clear the slice counter to 0, and go to RUN.
REQ-017 RUN: each cycle, slice k (bits 4k+3:4k) of the latched A and B plus the carry register SHALL be fed to the adder; the 4-bit sum SHALL be written to result bits 4k+3:4k; the adder carry-out SHALL be written to the carry register; k SHALL increment.
REQ-018 RUN: when k==NIB-1, the block SHALL go to DONE at that same edge, and carry_o SHALL take the final carry.
REQ-019 Latency: with handshake at edge T, res_valid_o SHALL be 1 after edge T+NIB (4 cycles for WIDTH=16).
REQ-020 DONE: res_valid_o=1; sum_o/carry_o SHALL hold stable until res_valid_o&&res_ready_i, then go to IDLE.
REQ-021 req_ready_o SHALL be 0 in RUN and DONE; req_valid_i SHALL be ignored there, with no queuing.
REQ-022 There is no pass-through: a new request SHALL be accepted no earlier than the cycle after result handshake.
REQ-023 The counter SHALL be ceil(log2(NIB)) bits wide (minimum 1) and SHALL NOT wrap within an operation.
REQ-024 Latched operands SHALL NOT change while in RUN or DONE, regardless of a_i, b_i or carry_i activity.

Reset
REQ-025 With rst_i=1 at an edge, the state SHALL be IDLE, and req_ready_o=1, res_valid_o=0, sum_o=0, carry_o=0; the counter and carry register SHALL be 0.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation; no res_valid_o pulse SHALL occur for the aborted request.
REQ-027 Reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-028 Macro RCA_SEQ_OVF_EN: when defined, the block SHALL add output ovf_o (1 bit), the signed two's-complement overflow = carry into MSB XOR carry out of MSB.
REQ-029 ovf_o SHALL be valid with res_valid_o, held during DONE, and reset to 0.
REQ-030 Without RCA_SEQ_OVF_EN, ovf_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package rca_pkg SHALL hold: the FSM state enum typedef (IDLE/RUN/DONE), the SLICE_W=4 constant, and the default WIDTH constant.
REQ-032 The block SHALL instantiate exactly one existing 4-bit rca sub-module (ports a_i, b_i, carry_i, sum_o, carry_o) as its datapath; no other adder logic is permitted.

Verification
REQ-033 WIDTH=16, A=0x1234, B=0x0FFF, cin=0 -> sum_o=0x2233, carry_o=0, res_valid_o exactly 4 cycles after the handshake.
REQ-034 A=0xFFFF, B=0x0001, cin=0 -> sum_o=0x0000, carry_o=1 (carry ripples through all slices).
REQ-035 A=0x8000, B=0x8000, cin=1 -> sum_o=0x0001, carry_o=1; with RCA_SEQ_OVF_EN, ovf_o=1; A=0x7FFF, B=0x0001, cin=0 -> sum_o=0x8000, ovf_o=1.
REQ-036 Backpressure: hold res_ready_i=0 for 3 cycles in DONE while toggling req_valid_i, a_i and b_i -> sum_o stable, req_ready_o=0, no new accept; res_ready_i=1 -> IDLE on the next cycle.
REQ-037 Reset at the 2nd RUN cycle of A=0xAAAA, B=0x5555 -> next cycle IDLE, res_valid_o=0, sum_o=0; a following request A=0x0009, B=0x0009, cin=1 -> sum_o=0x0013, carry_o=0.
REQ-038 Back-to-back: two requests with res_ready_i tied 1 -> second accepted one cycle after the first result handshake, and results are in order.
